// File: rtl/imem_loader_pkg.sv
// Shared Y86-64 instruction constants used by both the fetch-side decode and the
// instruction-memory loader.
package imem_loader_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int unsigned MEM_SIZE_DEFAULT = 2048;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/imem_loader_len_enc.sv
// Combinational icode classifier: validity, register byte, constant word and
// total encoded length. Encoder-side mirror of the fetch decode.
module instr_len_enc
  import imem_loader_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic       o_valid,
  output logic       o_need_regids,
  output logic       o_need_valc,
  output logic [3:0] o_len
);

  always_comb begin
    o_valid       = (i_icode <= IPOPQ);
    o_need_regids = i_icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    o_need_valc   = i_icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    o_len         = '0;
    if (o_valid) begin
      o_len = 4'd1 + (o_need_regids ? 4'd1 : 4'd0) + (o_need_valc ? 4'd8 : 4'd0);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Encodes one decoded Y86-64 instruction per handshake into its byte form and
// streams the bytes, one per cycle, into the instruction-memory write port.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT,
  parameter int unsigned ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] next_pc,
  output logic              busy,
  output logic              instr_err,
  output logic              imem_error
);

  localparam int unsigned AW1 = ADDR_W + 1;

  logic          w_valid;
  logic          w_need_regids;
  logic          w_need_valc;
  logic [3:0]    w_len;
  logic [63:0]   w_valc;
  logic [79:0]   w_buf;
  logic [AW1-1:0] w_end;
  logic          w_overflow;

  state_t            r_state;
  logic [ADDR_W-1:0] r_next_pc;
  logic [3:0]        r_idx;
  logic [3:0]        r_len;
  logic [79:0]       r_buf;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_instr_err;
  logic              r_imem_error;

  instr_len_enc u_len_enc (
    .i_icode       (icode),
    .o_valid       (w_valid),
    .o_need_regids (w_need_regids),
    .o_need_valc   (w_need_valc),
    .o_len         (w_len)
  );

  // Byte 0 sits in the low byte; the EMIT state shifts the buffer down one byte per write.
  always_comb begin
    w_valc     = w_need_valc ? valC : '0;
    w_buf      = w_need_regids ? {w_valc, rA, rB, icode, ifun}
                               : {8'h00, w_valc, icode, ifun};
    w_end      = {1'b0, r_next_pc} + AW1'(w_len);
    w_overflow = (w_end > AW1'(MEM_SIZE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_next_pc    <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_buf        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_instr_err  <= 1'b0;
      r_imem_error <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_instr_err  <= 1'b0;
      r_imem_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (pc_load) begin
            r_next_pc <= pc_in;
          end else if (in_valid) begin
            if (!w_valid) begin
              r_instr_err <= 1'b1;
            end else if (w_overflow) begin
              r_imem_error <= 1'b1;
            end else begin
              r_buf   <= w_buf;
              r_len   <= w_len;
              r_idx   <= '0;
              r_state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_next_pc + ADDR_W'(r_idx);
          r_wr_data <= r_buf[7:0];
          r_buf     <= {8'h00, r_buf[79:8]};
          if (r_idx == r_len - 4'd1) begin
            r_next_pc <= r_next_pc + ADDR_W'(r_len);
            r_idx     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE) && !pc_load;
  assign busy       = (r_state == ST_EMIT);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign next_pc    = r_next_pc;
  assign instr_err  = r_instr_err;
  assign imem_error = r_imem_error;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts one decoded Y86-64 instruction per handshake (icode, ifun, rA, rB, valC) and encodes it into its byte form:
  - byte0 = {icode,ifun}, then optional {rA,rB}, then optional valC as 8 bytes, little-endian.
- Streams the bytes, one per cycle, into the instruction-memory write port at a running program counter.
- Used to load test programs, so fetch reads back exactly what was loaded.

Parameters:
- MEM_SIZE, 2048, instruction memory depth in bytes; the last legal address is MEM_SIZE-1.
- ADDR_W, 64, width of the pc and write address (matches the fetch pc).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_load  in  1  load the write pointer (honoured only in IDLE).
- pc_in  in  ADDR_W  value loaded into the write pointer.
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  loader can accept an instruction: (state==IDLE) & !pc_load.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A.
- rB  in  4  register B.
- valC  in  64  constant word.
- wr_en  out  1  memory byte write strobe.
- wr_addr  out  ADDR_W  byte address for the write.
- wr_data  out  8  byte to write.
- next_pc  out  ADDR_W  current write pointer, i.e. valP of the last loaded instruction.
- busy  out  1  state==EMIT.
- instr_err  out  1  one-cycle pulse: a rejected instruction had icode > 4'hB.
- imem_error  out  1  one-cycle pulse: the instruction would run past MEM_SIZE-1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, next_pc=0, byte index=0.
  - wr_en=0, wr_addr=0, wr_data=0, instr_err=0, imem_error=0.
  - Reset mid-EMIT aborts immediately. Bytes already written stay written; no further writes occur.
- Instruction length is set by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmovXX, 6 OPq, A pushq, B popq: 2 bytes.
  - 7 jXX, 8 call: 9 bytes (no register byte).
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
- Register byte: need_regids = icode in {2,3,4,5,6,A,B}. Register byte = {rA,rB}, passed as presented (the caller supplies F for unused fields).
- IDLE state:
  - If pc_load: next_pc <= pc_in. Takes priority over in_valid, and in_ready is low that cycle.
  - Else if in_valid:
    - icode > B: instr_err pulses next cycle, nothing is written, next_pc unchanged, stay IDLE.
    - else if next_pc + len > MEM_SIZE (computed 65-bit, no wrap): imem_error pulses next cycle, nothing is written, stay IDLE.
    - else: latch a 10-byte buffer and len, set index=0, go to EMIT.
- EMIT state: each cycle drive wr_en=1, wr_addr=next_pc+index, wr_data=buf[index], then index++.
  - On the cycle with index==len-1: next_pc <= next_pc+len and state <= IDLE.
  - Latency: the first byte is registered in the cycle after acceptance, and len consecutive write cycles follow.
  - in_ready returns the cycle after the last byte. Back-to-back instructions therefore leave exactly one non-write cycle between them.
- Inputs changing during EMIT are ignored; the fields are latched at acceptance. pc_load during EMIT is ignored.
- wr_en is 0 in every non-EMIT cycle. wr_addr and wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package / header holds:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ.
  - RNONE = 4'hF.
  - MEM_SIZE default.
  - These are the same constants the fetch-side need_regids / need_valC / instr_valid logic uses.
- One combinational sub-module, instr_len_enc: icode -> {valid, need_regids, need_valC, len[3:0]}. It is the exact encoder-side mirror of the fetch decode, and the FSM, buffer and pointer stay in imem_loader.

Test Plan:
- irmovq at pc 0: reset, icode=3, ifun=0, rA=F, rB=3, valC=64'h0123456789ABCDEF. Required response:
  - wr_data 30 F3 EF CD AB 89 67 45 23 01 on wr_addr 0..9 over 10 consecutive cycles.
  - next_pc=10.
  - Reading the bytes back through fetch yields icode=3, rB=3, valC matching, valP=10.
- Back-to-back 60 01 then jmp 0x20:
  - Two write cycles at addrs 10..11, then one idle cycle.
  - Then 70 20 00 00 00 00 00 00 00 at 12..20, next_pc=21.
- halt after pc_load=112: a single write of 00 at 112, next_pc=113, busy high for exactly 1 cycle.
- Invalid icode C: instr_err=1 for one cycle, wr_en stays 0, next_pc unchanged, in_ready high again the next cycle.
- Overflow: with pc_load=2042, rmmovq (len 10) -> imem_error pulse and no writes. Then nop -> 10 written at 2042, next_pc=2043.
- Reset mid-EMIT: assert rst_n=0 after 4 of 10 bytes. Outputs clear immediately and no further wr_en. After release, in_ready=1 and next_pc=0.
